// File: rtl/seg_pipe_adder.sv
// Segmented, pipelined add/subtract unit: one SEG-bit slice per stage, valid/ready on both sides.
// Optional saturation on signed overflow when SEG_PIPE_ADDER_SAT_EN is defined (adds the sat input).
module seg_pipe_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
`ifdef SEG_PIPE_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned STAGES = WIDTH / SEG;
  localparam int unsigned LAST   = STAGES - 1;
  localparam int unsigned PIPE   = (STAGES > 1) ? STAGES - 1 : 1;

  // Inter-stage registers: acc holds summed low slices and untouched high slices of A
  logic [WIDTH-1:0] acc_q [PIPE];
  logic [WIDTH-1:0] bop_q [PIPE];
  logic [PIPE-1:0]  cy_q;
  logic [PIPE-1:0]  vld_q;
`ifdef SEG_PIPE_ADDER_SAT_EN
  logic [PIPE-1:0]  sat_q;
  logic [STAGES-1:0] src_sat;
`endif

  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;
  logic             out_vld_q;

  logic [WIDTH-1:0] src_acc [STAGES];
  logic [WIDTH-1:0] src_bop [STAGES];
  logic [WIDTH-1:0] nxt_acc [STAGES];
  logic [STAGES-1:0] src_cy;
  logic [STAGES-1:0] src_vld;
  logic [STAGES-1:0] nxt_cy;
  logic [SEG:0]      sl;
  logic [WIDTH-1:0]  fin_sum;
  logic              fin_ovf;
  logic              adv;

  assign adv       = out_ready | ~out_vld_q;
  assign in_ready  = adv;
  assign out_valid = out_vld_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

  // Per-stage slice add; stage 0 takes operands straight from the ports
  always_comb begin
    src_acc[0] = a;
    src_bop[0] = b ^ {WIDTH{sub}};
    src_cy[0]  = sub | cin;
    src_vld[0] = in_valid;
`ifdef SEG_PIPE_ADDER_SAT_EN
    src_sat[0] = sat;
`endif
    for (int k = 1; k < STAGES; k++) begin
      src_acc[k] = acc_q[k-1];
      src_bop[k] = bop_q[k-1];
      src_cy[k]  = cy_q[k-1];
      src_vld[k] = vld_q[k-1];
`ifdef SEG_PIPE_ADDER_SAT_EN
      src_sat[k] = sat_q[k-1];
`endif
    end
    sl = '0;
    for (int k = 0; k < STAGES; k++) begin
      sl = {1'b0, src_acc[k][k*SEG +: SEG]} + {1'b0, src_bop[k][k*SEG +: SEG]}
         + {{SEG{1'b0}}, src_cy[k]};
      nxt_acc[k] = src_acc[k];
      nxt_acc[k][k*SEG +: SEG] = sl[SEG-1:0];
      nxt_cy[k] = sl[SEG];
    end
    // Top slice of src_acc[LAST] is still the original A, so its MSB is A[MSB]
    fin_ovf = (src_acc[LAST][WIDTH-1] == src_bop[LAST][WIDTH-1]) &
              (nxt_acc[LAST][WIDTH-1] != src_acc[LAST][WIDTH-1]);
    fin_sum = nxt_acc[LAST];
`ifdef SEG_PIPE_ADDER_SAT_EN
    if (src_sat[LAST] && fin_ovf) begin
      fin_sum = src_acc[LAST][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE; k++) begin
        acc_q[k] <= '0;
        bop_q[k] <= '0;
      end
      cy_q      <= '0;
      vld_q     <= '0;
`ifdef SEG_PIPE_ADDER_SAT_EN
      sat_q     <= '0;
`endif
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      out_vld_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES - 1; k++) begin
        acc_q[k] <= nxt_acc[k];
        bop_q[k] <= src_bop[k];
        cy_q[k]  <= nxt_cy[k];
        vld_q[k] <= src_vld[k];
`ifdef SEG_PIPE_ADDER_SAT_EN
        sat_q[k] <= src_sat[k];
`endif
      end
      sum_q     <= fin_sum;
      cout_q    <= nxt_cy[LAST];
      ovf_q     <= fin_ovf;
      zero_q    <= ~|fin_sum;
      out_vld_q <= src_vld[LAST];
    end
  end

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Self-checking bench for seg_pipe_adder: directed corners, stall, mid-flight reset, random traffic
// against an integer-arithmetic reference model.
module tb_seg_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        cin;
  logic        sub;
  logic        sat;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  int n_checks = 0;
  int n_pass   = 0;
  int n_out    = 0;

  logic [34:0] exp_q [$];
  logic        got_out;
  logic [34:0] got_val;
  logic        accepted;
  logic        held_v;
  logic [35:0] held;
  logic        stall_chk;

  seg_pipe_adder #(.WIDTH(32), .SEG(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
`ifdef SEG_PIPE_ADDER_SAT_EN
    .sat       (sat),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: exact integer arithmetic, result packed as {cout, ovf, zero, sum}
  function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mcin, input logic msub, input logic msat);
    longint      sr;
    logic [63:0] ua;
    logic [31:0] s;
    logic        co;
    logic        ov;
    if (!msub) begin
      sr = longint'($signed(ma)) + longint'($signed(mb)) + longint'(mcin);
      ua = 64'(ma) + 64'(mb) + 64'(mcin);
      co = ua[32];
    end else begin
      sr = longint'($signed(ma)) - longint'($signed(mb));
      co = (ma >= mb);
    end
    s  = 32'(sr);
    ov = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    if (msat && ov) s = (sr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    return {co, ov, (s == 32'h0), s};
  endfunction

  // One clock: drive at negedge, observe handshakes, update the scoreboard
  task automatic step(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                      input logic icin, input logic isub, input logic isat,
                      input logic ordy, input logic irst);
    @(negedge clk);
    in_valid = iv; a = ia; b = ib; cin = icin; sub = isub; sat = isat;
    out_ready = ordy; rst = irst;
    #1;
    got_out  = 1'b0;
    accepted = 1'b0;
    if (!irst) begin
      if (held_v) begin
        check("hold", 64'({out_valid, cout, ovf, zero, sum}), 64'(held));
        held_v = 1'b0;
      end
      if (stall_chk && out_valid && !out_ready) check("stall_in_ready", 64'(in_ready), 64'(0));
      if (out_valid && !out_ready) begin
        held   = {out_valid, cout, ovf, zero, sum};
        held_v = 1'b1;
      end
      if (out_valid && out_ready) begin
        got_out = 1'b1;
        got_val = {cout, ovf, zero, sum};
        n_out++;
        if (exp_q.size() == 0) check("spurious_out", 64'(out_valid), 64'(0));
        else check("result", 64'(got_val), 64'(exp_q.pop_front()));
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(ia, ib, icin, isub, isat));
        accepted = 1'b1;
      end
    end else begin
      exp_q.delete();
      held_v = 1'b0;
    end
  endtask

  // Single operation with free-flowing output; checks literal expectation and latency
  task automatic run_one(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                         input logic icin, input logic isub, input logic isat,
                         input logic [34:0] exp);
    int cnt;
    step(1'b1, ia, ib, icin, isub, isat, 1'b1, 1'b0);
    check({tag, "_accept"}, 64'(accepted), 64'(1));
    cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      if (got_out) begin
        cnt = i;
        break;
      end
    end
    check({tag, "_latency"}, 64'(cnt), 64'(4));
    check({tag, "_value"}, 64'(got_val), 64'(exp));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    int base;
    int sent;
    logic [31:0] pa;
    logic [31:0] pb;
    held_v = 1'b0; stall_chk = 1'b0; got_val = '0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; sat = 1'b0;
    out_ready = 1'b0; rst = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    check("reset_outputs", 64'({cout, ovf, zero, sum}), 64'(0));

    run_one("carry_slice0", 32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, {3'b000, 32'h0000_0100});
    run_one("ripple_all",   32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, {3'b101, 32'h0000_0000});
    run_one("pos_ovf",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0, {3'b010, 32'h8000_0000});
    run_one("sub_borrow",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 1'b0, {3'b000, 32'hFFFF_FFFE});
    run_one("sub_noborrow", 32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 1'b0, {3'b100, 32'h0000_0002});
    run_one("sub_cin_ign",  32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 1'b0, {3'b100, 32'h0000_0002});
    run_one("add_cin",      32'h0000_00FF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, {3'b000, 32'h0000_0100});
    run_one("sub_neg_ovf",  32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b0, {3'b110, 32'h7FFF_FFFF});
`ifdef SEG_PIPE_ADDER_SAT_EN
    run_one("sat_pos",      32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, {3'b010, 32'h7FFF_FFFF});
    run_one("sat_neg",      32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, {3'b110, 32'h8000_0000});
`endif

    // Eight back-to-back inputs with the consumer stalled on cycles 6..9
    base = n_out; sent = 0; stall_chk = 1'b1;
    pa = $urandom(); pb = $urandom();
    for (int i = 0; i < 30; i++) begin
      step(sent < 8, pa, pb, 1'b0, pa[0], 1'b0, !(i >= 6 && i <= 9), 1'b0);
      if (accepted) begin
        sent++;
        pa = $urandom(); pb = $urandom();
      end
    end
    stall_chk = 1'b0;
    check("stall_sent", 64'(sent), 64'(8));
    check("stall_delivered", 64'(n_out - base), 64'(8));
    check("stall_queue_empty", 64'(exp_q.size()), 64'(0));

    // Three results in flight, then a one-cycle reset must discard them all
    for (int i = 0; i < 3; i++) step(1'b1, $urandom(), $urandom(), 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    base = n_out;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    for (int i = 0; i < 6; i++) begin
      check("rst_no_stale", 64'(out_valid), 64'(0));
      step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    check("rst_no_outputs", 64'(n_out - base), 64'(0));
    run_one("post_rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0, {3'b000, 32'h2345_6789});

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) < 7, pick(), pick(), 1'(($urandom() >> 3) & 1),
           1'(($urandom() >> 5) & 1),
`ifdef SEG_PIPE_ADDER_SAT_EN
           1'(($urandom() >> 7) & 1),
`else
           1'b0,
`endif
           $urandom_range(0, 9) < 7, 1'b0);
    end
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("drain_empty", 64'(exp_q.size()), 64'(0));
    check("drain_idle", 64'(out_valid), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
